load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, byte-address width presented to memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, memory bus width; only 8 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port res_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port lsu_req, input, 1, core request valid; held until lsu_done.
REQ-006 SHALL have port lsu_wr, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port lsu_size, input, 2, 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-008 SHALL have port lsu_zero_ex, input, 1, load extension: 1 = zero, 0 = sign.
REQ-009 SHALL have port lsu_addr, input, 32, byte address.
REQ-010 SHALL have port lsu_wr_data, input, 32, store data, little-endian.
REQ-011 SHALL have port lsu_rd_data, output, 32, extended load result.
REQ-012 SHALL have port lsu_done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port lsu_err, output, 1, misaligned or illegal-size flag, valid with lsu_done.
REQ-014 SHALL have port lsu_stall, output, 1, hold core PC: lsu_req & ~lsu_done.
REQ-015 SHALL have port mem_req, output, 1, byte access strobe.
REQ-016 SHALL have port mem_we, output, 1, byte write enable.
REQ-017 SHALL have port mem_addr, output, ADDR_WIDTH, byte address lsu_addr[ADDR_WIDTH-1:0] + offset.
REQ-018 SHALL have port mem_wdata, output, 8, byte to write.
REQ-019 SHALL have port mem_rdata, input, 8, read byte, valid in the cycle mem_ready is high.
REQ-020 SHALL have port mem_ready, input, 1, memory accepts or returns the current byte.

Function
REQ-021 SHALL implement FSM states IDLE, XFER, DONE.
REQ-022 IDLE: on lsu_req, SHALL latch all inputs, clear the byte counter, and go to XFER; if misaligned or size 11, SHALL go directly to DONE with err set.
REQ-023 Misaligned SHALL mean half with addr[0] = 1, or word with addr[1:0] != 00.
REQ-024 XFER SHALL assert mem_req with byte index cnt; mem_addr = base + cnt; mem_wdata = wr_data[8*cnt+7:8*cnt].
REQ-025 Each cycle of mem_req & mem_ready SHALL complete one byte; loads SHALL capture mem_rdata into byte lane cnt, and cnt SHALL increment.
REQ-026 After the last byte (cnt = 0/1/3 for byte/half/word), SHALL go to DONE; mem_ready low SHALL hold all outputs stable.
REQ-027 DONE SHALL pulse lsu_done for exactly one cycle, then return to IDLE; a new request SHALL not be accepted in the DONE cycle.
REQ-028 lsu_rd_data SHALL be sign- or zero-extended from bit 7 or 15 per lsu_zero_ex; word loads unchanged; stores and errors SHALL give 0.
REQ-029 lsu_rd_data SHALL hold its value until the next completion.
REQ-030 Latency SHALL be N+1 cycles from acceptance to lsu_done with mem_ready tied high (N = 1/2/4); error latency SHALL be 1 cycle.
REQ-031 mem_req SHALL never be asserted in IDLE or DONE, nor for erroneous requests.
REQ-032 Address addition SHALL wrap modulo 2^ADDR_WIDTH.
REQ-033 lsu_req dropped mid-transfer SHALL be ignored; the transfer SHALL complete.

Reset
REQ-034 While res_n = 0: state = IDLE, cnt = 0, lsu_rd_data = 0; lsu_done, lsu_err, mem_req and mem_we = 0.
REQ-035 Reset mid-XFER SHALL abort immediately with no further mem_req; first access after release SHALL start from IDLE.

Verification
REQ-036 LW, addr 0x10, bytes 11,22,33,44, ready high -> rd_data 0x44332211; done at cycle 5; four mem_req at addr 0x10..0x13.
REQ-037 LB, sign ext, byte 0x80 -> rd_data 0xFFFFFF80; with LBU -> 0x00000080.
REQ-038 SH, addr 0x22, data 0xDEADBEEF -> writes EF to 0x22 and BE to 0x23 only; rd_data 0.
REQ-039 LW, addr 0x02 -> done and err at cycle 1; no mem_req.
REQ-040 LW with mem_ready low for 3 cycles on byte 2 -> addr and wdata held stable; done at cycle 8.
REQ-041 res_n low during byte 1 of SW -> mem_req drops asynchronously; next LB completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response and byte-wide memory bus bundle for the load/store unit.
// The slave modport is the LSU itself; master is the core plus memory environment.
interface load_store_unit_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  lsu_req;
   logic                  lsu_wr;
   logic [1:0]            lsu_size;
   logic                  lsu_zero_ex;
   logic [31:0]           lsu_addr;
   logic [31:0]           lsu_wr_data;
   logic [31:0]           lsu_rd_data;
   logic                  lsu_done;
   logic                  lsu_err;
   logic                  lsu_stall;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ready;

   modport slave (
      input  lsu_req, lsu_wr, lsu_size, lsu_zero_ex, lsu_addr, lsu_wr_data,
      output lsu_rd_data, lsu_done, lsu_err, lsu_stall,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport master (
      output lsu_req, lsu_wr, lsu_size, lsu_zero_ex, lsu_addr, lsu_wr_data,
      input  lsu_rd_data, lsu_done, lsu_err, lsu_stall,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: splits byte/half/word core accesses into sequential byte
// transfers on an 8-bit memory bus, with alignment checking and load extension.
module load_store_unit #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic             clk,
   input  logic             res_n,
   load_store_unit_if.slave bus
);
   localparam int unsigned WORD_W = 32;
   localparam int unsigned CNT_W  = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_BAD  = 2'b11;

   logic [1:0]            state_q,  state_d;
   logic [CNT_W-1:0]      cnt_q,    cnt_d;
   logic [CNT_W-1:0]      cnt_nxt;
   logic [ADDR_WIDTH-1:0] base_q,   base_d;
   logic [WORD_W-1:0]     wdata_q,  wdata_d;
   logic                  wr_q,     wr_d;
   logic [1:0]            size_q,   size_d;
   logic                  zx_q,     zx_d;
   logic [WORD_W-1:0]     rbuf_q,   rbuf_d;
   logic [WORD_W-1:0]     rd_q,     rd_d;
   logic                  done_q,   done_d;
   logic                  err_q,    err_d;
   logic                  mreq_q,   mreq_d;
   logic                  mwe_q,    mwe_d;
   logic [ADDR_WIDTH-1:0] maddr_q,  maddr_d;
   logic [DATA_WIDTH-1:0] mwdata_q, mwdata_d;

   logic                  bad_c;
   logic [CNT_W-1:0]      last_c;

   function automatic int unsigned lane(input logic [CNT_W-1:0] idx);
      return DATA_WIDTH * 32'(idx);
   endfunction

   function automatic logic [WORD_W-1:0] extend(input logic [WORD_W-1:0] w,
                                                input logic [1:0] sz,
                                                input logic zx);
      case (sz)
         SZ_BYTE: return zx ? {24'b0, w[7:0]}  : {{24{w[7]}},  w[7:0]};
         SZ_HALF: return zx ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
         default: return w;
      endcase
   endfunction

   // Illegal size or misaligned half/word requests complete at once with an error
   assign bad_c = (bus.lsu_size == SZ_BAD) ||
                  ((bus.lsu_size == SZ_HALF) && bus.lsu_addr[0]) ||
                  ((bus.lsu_size == SZ_WORD) && (bus.lsu_addr[1:0] != 2'b00));

   assign last_c = (size_q == SZ_WORD) ? 2'd3 : ((size_q == SZ_HALF) ? 2'd1 : 2'd0);

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      base_d   = base_q;
      wdata_d  = wdata_q;
      wr_d     = wr_q;
      size_d   = size_q;
      zx_d     = zx_q;
      rbuf_d   = rbuf_q;
      rd_d     = rd_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      mreq_d   = mreq_q;
      mwe_d    = mwe_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      cnt_nxt  = cnt_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (bus.lsu_req) begin
               wr_d    = bus.lsu_wr;
               size_d  = bus.lsu_size;
               zx_d    = bus.lsu_zero_ex;
               base_d  = bus.lsu_addr[ADDR_WIDTH-1:0];
               wdata_d = bus.lsu_wr_data;
               cnt_d   = '0;
               rbuf_d  = '0;
               if (bad_c) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  rd_d    = '0;
               end else begin
                  state_d  = ST_XFER;
                  mreq_d   = 1'b1;
                  mwe_d    = bus.lsu_wr;
                  maddr_d  = bus.lsu_addr[ADDR_WIDTH-1:0];
                  mwdata_d = bus.lsu_wr_data[DATA_WIDTH-1:0];
               end
            end
         end
         ST_XFER: begin
            // mem_ready low leaves every register untouched
            if (bus.mem_ready) begin
               if (!wr_q) rbuf_d[lane(cnt_q) +: DATA_WIDTH] = bus.mem_rdata;
               if (cnt_q == last_c) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  mreq_d  = 1'b0;
                  mwe_d   = 1'b0;
                  rd_d    = wr_q ? '0 : extend(rbuf_d, size_q, zx_q);
               end else begin
                  cnt_d    = cnt_nxt;
                  maddr_d  = base_q + ADDR_WIDTH'(cnt_nxt);
                  mwdata_d = wdata_q[lane(cnt_nxt) +: DATA_WIDTH];
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         base_q   <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         size_q   <= SZ_BYTE;
         zx_q     <= 1'b0;
         rbuf_q   <= '0;
         rd_q     <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         mreq_q   <= 1'b0;
         mwe_q    <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         base_q   <= base_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
         size_q   <= size_d;
         zx_q     <= zx_d;
         rbuf_q   <= rbuf_d;
         rd_q     <= rd_d;
         done_q   <= done_d;
         err_q    <= err_d;
         mreq_q   <= mreq_d;
         mwe_q    <= mwe_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
      end
   end

   assign bus.lsu_rd_data = rd_q;
   assign bus.lsu_done    = done_q;
   assign bus.lsu_err     = err_q;
   assign bus.lsu_stall   = bus.lsu_req & ~done_q;
   assign bus.mem_req     = mreq_q;
   assign bus.mem_we      = mwe_q;
   assign bus.mem_addr    = maddr_q;
   assign bus.mem_wdata   = mwdata_q;

   // Core address bits above the memory window are intentionally dropped
   if (ADDR_WIDTH < WORD_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.lsu_addr[WORD_W-1:ADDR_WIDTH];
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model predicts every
// cycle of the memory bus and core response; a single process compares each cycle.
module tb_load_store_unit;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;

   logic clk = 1'b0;
   logic res_n = 1'b0;
   always #5 clk = ~clk;

   load_store_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .res_n (res_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic          req;
      logic          we;
      logic [AW-1:0] addr;
      logic [7:0]    wdata;
      logic          done;
      logic          err;
      logic [31:0]   rd;
      logic          ready;
      logic [7:0]    rdata;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [7:0]  mem_model [0:65535];
   logic [31:0] last_rd = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
      end
   endtask

   // Per-cycle comparison against the model's timeline; also plays the memory side
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else e = '0;
         if (!res_n) last_rd = '0;
         else if (e.done) last_rd = e.rd;
         check("mem_req", 32'(bus.mem_req), 32'(e.req));
         if (e.req) begin
            check("mem_we", 32'(bus.mem_we), 32'(e.we));
            check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
            check("mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
         end
         check("lsu_done", 32'(bus.lsu_done), 32'(e.done));
         if (e.done) check("lsu_err", 32'(bus.lsu_err), 32'(e.err));
         check("lsu_rd_data", bus.lsu_rd_data, last_rd);
         check("lsu_stall", 32'(bus.lsu_stall), 32'(bus.lsu_req & ~e.done));
         bus.mem_ready = e.ready;
         bus.mem_rdata = e.rdata;
      end
   end

   task automatic run_txn(input string name, input logic wr, input logic [1:0] size,
                          input logic zx, input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall_byte, input int stall_cyc, input int drop_cyc,
                          input bit keep_req, input logic [31:0] lit_rd,
                          input logic lit_err, input int lit_lat);
      bit          bad;
      int          n;
      int          v;
      int          cyc;
      logic [31:0] word;
      logic [31:0] rd;
      logic [AW-1:0] a;
      exp_t        e;

      @(posedge clk); #1;
      bus.lsu_req     = 1'b1;
      bus.lsu_wr      = wr;
      bus.lsu_size    = size;
      bus.lsu_zero_ex = zx;
      bus.lsu_addr    = addr;
      bus.lsu_wr_data = wdata;
      @(posedge clk);

      bad  = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
             (size == 2'b10 && addr[1:0] != 2'b00);
      n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      word = '0;
      if (!bad) begin
         for (int i = 0; i < n; i++) begin
            a = AW'(addr + 32'(i));
            e = '0;
            e.req   = 1'b1;
            e.we    = wr;
            e.addr  = a;
            e.wdata = wdata[8*i +: 8];
            for (int s = 0; s < ((i == stall_byte) ? stall_cyc : 0); s++) exp_q.push_back(e);
            e.ready = 1'b1;
            e.rdata = mem_model[a];
            exp_q.push_back(e);
            if (wr) mem_model[a] = wdata[8*i +: 8];
            else    word = word | (32'(mem_model[a]) << (8*i));
         end
      end
      if (bad || wr) rd = '0;
      else if (n == 1) begin
         v = int'(word[7:0]);
         if (!zx && v >= 128) v = v - 256;
         rd = 32'(v);
      end else if (n == 2) begin
         v = int'(word[15:0]);
         if (!zx && v >= 32768) v = v - 65536;
         rd = 32'(v);
      end else rd = word;
      e = '0;
      e.done = 1'b1;
      e.err  = bad;
      e.rd   = rd;
      exp_q.push_back(e);

      cyc = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (bus.lsu_done) break;
         if (cyc == drop_cyc) begin #1; bus.lsu_req = 1'b0; end
         if (cyc >= 40) begin
            n_cmp++; n_fail++;
            $display("FAIL %s timeout: no lsu_done after %0d cycles, expected %0d", name, cyc, lit_lat);
            exp_q.delete();
            break;
         end
      end
      check({name, " latency"}, 32'(cyc), 32'(lit_lat));
      check({name, " rd_data"}, bus.lsu_rd_data, lit_rd);
      check({name, " err"}, 32'(bus.lsu_err), 32'(lit_err));
      if (!keep_req) begin
         @(posedge clk); #1;
         bus.lsu_req = 1'b0;
      end
   endtask

   initial begin
      exp_t e;
      bus.lsu_req = 1'b0; bus.lsu_wr = 1'b0; bus.lsu_size = 2'b00; bus.lsu_zero_ex = 1'b0;
      bus.lsu_addr = '0; bus.lsu_wr_data = '0; bus.mem_rdata = '0; bus.mem_ready = 1'b0;
      for (int i = 0; i < 65536; i++) mem_model[i] = 8'(i * 37 + 5);
      mem_model[16'h0010] = 8'h11; mem_model[16'h0011] = 8'h22;
      mem_model[16'h0012] = 8'h33; mem_model[16'h0013] = 8'h44;
      mem_model[16'h0040] = 8'h80;

      repeat (3) @(posedge clk);
      #1;
      check("reset lsu_err", 32'(bus.lsu_err), 32'h0);
      check("reset mem_we", 32'(bus.mem_we), 32'h0);
      res_n = 1'b1;

      //      name           wr    size   zx    addr          wdata         sb  sc  drop keep lit_rd        err  lat
      run_txn("LW 0x10",     1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        -1, 0, -1, 0, 32'h4433_2211, 1'b0, 5);
      run_txn("LB 0x40",     1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'h0,        -1, 0, -1, 0, 32'hFFFF_FF80, 1'b0, 2);
      run_txn("LBU 0x40",    1'b0, 2'b00, 1'b1, 32'h0000_0040, 32'h0,        -1, 0, -1, 0, 32'h0000_0080, 1'b0, 2);
      run_txn("SH 0x22",     1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'hDEAD_BEEF, -1, 0, -1, 0, 32'h0,         1'b0, 3);
      run_txn("LH 0x22",     1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0,        -1, 0, -1, 1, 32'hFFFF_BEEF, 1'b0, 3);
      run_txn("LHU 0x22",    1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0,        -1, 0, -1, 0, 32'h0000_BEEF, 1'b0, 3);
      run_txn("LW 0x02",     1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0,        -1, 0, -1, 0, 32'h0,         1'b1, 1);
      run_txn("size 11",     1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        -1, 0, -1, 0, 32'h0,         1'b1, 1);
      run_txn("LH 0x23",     1'b0, 2'b01, 1'b0, 32'h0000_0023, 32'h0,        -1, 0, -1, 0, 32'h0,         1'b1, 1);
      run_txn("LW stall",    1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         2, 3, -1, 0, 32'h4433_2211, 1'b0, 8);
      run_txn("SW high",     1'b1, 2'b10, 1'b0, 32'h0001_FFFC, 32'hCAFE_F00D, 0, 1, -1, 0, 32'h0,         1'b0, 6);
      run_txn("LW high",     1'b0, 2'b10, 1'b0, 32'h0001_FFFC, 32'h0,        -1, 0, -1, 0, 32'hCAFE_F00D, 1'b0, 5);
      run_txn("LW drop",     1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        -1, 0,  2, 0, 32'h4433_2211, 1'b0, 5);
      run_txn("SB 0x50",     1'b1, 2'b00, 1'b0, 32'h0000_0050, 32'h0000_00A5, -1, 0, -1, 0, 32'h0,        1'b0, 2);
      run_txn("LB 0x50",     1'b0, 2'b00, 1'b0, 32'h0000_0050, 32'h0,        -1, 0, -1, 0, 32'hFFFF_FFA5, 1'b0, 2);

      // Reset asserted while the second byte of a word store is stalled
      @(posedge clk); #1;
      bus.lsu_req = 1'b1; bus.lsu_wr = 1'b1; bus.lsu_size = 2'b10; bus.lsu_zero_ex = 1'b0;
      bus.lsu_addr = 32'h0000_0030; bus.lsu_wr_data = 32'h0102_0304;
      @(posedge clk);
      e = '0; e.req = 1'b1; e.we = 1'b1; e.addr = AW'(16'h0030); e.wdata = 8'h04; e.ready = 1'b1;
      exp_q.push_back(e);
      e.addr = AW'(16'h0031); e.wdata = 8'h03; e.ready = 1'b0;
      exp_q.push_back(e);
      mem_model[16'h0030] = 8'h04;
      @(negedge clk);
      @(negedge clk);
      #1;
      res_n = 1'b0;
      #1;
      check("async reset mem_req", 32'(bus.mem_req), 32'h0);
      check("async reset mem_we", 32'(bus.mem_we), 32'h0);
      check("async reset lsu_done", 32'(bus.lsu_done), 32'h0);
      check("async reset rd_data", bus.lsu_rd_data, 32'h0);
      exp_q.delete();
      bus.lsu_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      res_n = 1'b1;
      run_txn("LB after rst", 1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'h0,      -1, 0, -1, 0, 32'hFFFF_FF80, 1'b0, 2);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end
endmodule
